// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller:
// FSM states, opcodes, ImmSrc, ALUOp and ALUControl values.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format select, purely a function of the opcode.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function
// fields onto the ALUControl select.
import multicycle_controller_pkg::*;

module alu_decoder (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    // Only R-type (op[5]=1) may turn funct3=000 into sub,
    // so addi with Instr[30] set still adds.
    always_comb begin
        alu_control_o = ALU_ADD;
        unique case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000: begin
                        if (op5_i && funct7b5_i)
                            alu_control_o = ALU_SUB;
                        else
                            alu_control_o = ALU_ADD;
                    end
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: decodes the IR fields
// and drives every datapath control line per cycle.
import multicycle_controller_pkg::*;

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    state_t cur;
    aluop_t alu_op;
    logic   pc_update;
    logic   branch;
    logic   ir_write;
    logic   reg_write;
    logic   mem_write;
    logic   op_legal;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // While reset is held the outputs mirror FETCH,
    // whatever instruction was in flight.
    assign cur = reset ? S_FETCH : state_q;

    assign op_legal = (op == OP_LOAD)   ||
                      (op == OP_STORE)  ||
                      (op == OP_RTYPE)  ||
                      (op == OP_ITYPE)  ||
                      (op == OP_BRANCH) ||
                      (op == OP_JAL);

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD:   state_d = S_MEMADR;
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_BRANCH: state_d = S_BEQ;
                    OP_JAL:    state_d = S_JAL;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD)
                    state_d = S_MEMREAD;
                else
                    state_d = S_MEMWRITE;
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode of the current state.
    always_comb begin
        AdrSrc    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        case (cur)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & reg_write;
    assign MemWrite = ~reset & mem_write;
    assign Illegal  = ~reset & (state_q == S_DECODE) & ~op_legal;
    assign ImmSrc   = imm_src(op);
    assign State    = cur;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALUControl)
    );

endmodule
